// File: rtl/enc8b10b_pkg.sv
// enc8b10b_pkg: symbol width, K28.5 comma constants and disparity classes shared by the 8b/10b path.
package enc8b10b_pkg;
  localparam int SYM_W = 10;
  localparam logic [SYM_W-1:0] K28_5_NEG = 10'b0011111010;
  localparam logic [SYM_W-1:0] K28_5_POS = 10'b1100000101;
  typedef enum logic [1:0] {DISP_NEUTRAL, DISP_POS, DISP_NEG, DISP_BAD} disp_t;
endpackage

// File: rtl/sym_disp.sv
// sym_disp: classifies a 10-bit symbol by ones-count (5 neutral, 6 positive, 4 negative, else bad).
module sym_disp
  import enc8b10b_pkg::*;
(
  input  logic [SYM_W-1:0] sym,
  output disp_t            disp
);
  logic [3:0] ones;
  always_comb begin
    ones = '0;
    for (int i = 0; i < SYM_W; i++) ones = ones + {3'b0, sym[i]};
    disp = ones == 4'd5 ? DISP_NEUTRAL :
           ones == 4'd6 ? DISP_POS :
           ones == 4'd4 ? DISP_NEG : DISP_BAD;
  end
endmodule

// File: rtl/ser10b_tx.sv
// ser10b_tx: 10b symbol serializer, MSB (a) first, with one-entry hold, comma idle insertion
// and running-disparity tracking fed back to the encoder.
module ser10b_tx
  import enc8b10b_pkg::*;
#(
  parameter int SYM_W   = 10,
  parameter bit IDLE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SYM_W-1:0] sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic             ser_out,
  output logic             sym_start,
  output logic             is_idle,
  output logic             rd_out,
  output logic             disp_err
);
  logic [SYM_W-1:0] shreg, hold, nxt, idle_sym;
  logic [3:0] bit_cnt;
  logic hold_full, rd, idle_q, err_q;
  logic load, xfer, use_idle, upd;
  disp_t disp;
  assign load      = bit_cnt == 4'd9;
  assign sym_ready = !hold_full || load;
  assign xfer      = sym_valid && sym_ready;
  assign use_idle  = !hold_full && !sym_valid;
  assign idle_sym  = !IDLE_EN ? '0 : rd ? K28_5_POS : K28_5_NEG;
  assign nxt       = hold_full ? hold : sym_valid ? sym_in : idle_sym;
  // the all-zero filler is not a real symbol, so it must not touch disparity state
  assign upd       = !(use_idle && !IDLE_EN);
  sym_disp u_disp (.sym(nxt), .disp(disp));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      hold      <= '0;
      bit_cnt   <= 4'd9;
      hold_full <= 1'b0;
      rd        <= 1'b0;
      idle_q    <= 1'b0;
      err_q     <= 1'b0;
    end else if (load) begin
      shreg     <= nxt;
      bit_cnt   <= 4'd0;
      idle_q    <= use_idle;
      hold_full <= hold_full && sym_valid;
      if (hold_full && sym_valid) hold <= sym_in;
      if (upd) begin
        rd    <= disp == DISP_POS ? 1'b1 : disp == DISP_NEG ? 1'b0 : rd;
        err_q <= err_q || disp == DISP_BAD;
      end
    end else begin
      shreg   <= {shreg[SYM_W-2:0], 1'b0};
      bit_cnt <= bit_cnt + 4'd1;
      if (xfer) begin
        hold      <= sym_in;
        hold_full <= 1'b1;
      end
    end
  end
  assign ser_out   = shreg[SYM_W-1];
  assign sym_start = bit_cnt == 4'd0;
  assign is_idle   = idle_q;
  assign rd_out    = rd;
  assign disp_err  = err_q;
endmodule

// File: tb/tb_ser10b_tx.sv
// tb_ser10b_tx: table, directed and random checks of ser10b_tx against a symbol-queue model.
module tb_ser10b_tx;
  localparam logic [9:0] KN = 10'b0011111010;
  localparam logic [9:0] KP = 10'b1100000101;
  localparam logic [9:0] D00 = 10'b1001110100;
  localparam logic [9:0] SA = 10'b1010101010;
  localparam logic [9:0] SB = 10'b1110001011;
  logic clk = 0, rst_n = 0, sym_valid = 0;
  logic [9:0] sym_in = '0;
  logic sym_ready, ser_out, sym_start, is_idle, rd_out, disp_err;
  int pass_cnt = 0, tot = 0;
  ser10b_tx dut (
    .clk(clk), .rst_n(rst_n), .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .ser_out(ser_out), .sym_start(sym_start), .is_idle(is_idle), .rd_out(rd_out), .disp_err(disp_err)
  );
  always #5 clk = ~clk;
  logic [9:0] m_cur;
  logic [9:0] m_q[$];
  int m_pos;
  logic m_rd, m_idle, m_err;
  logic got[$];
  function void m_reset();
    m_cur = '0; m_pos = 9; m_q.delete(); m_rd = 0; m_idle = 0; m_err = 0;
  endfunction
  function logic m_ready();
    return m_q.size() == 0 || m_pos == 9;
  endfunction
  function void m_step();
    logic acc;
    logic [9:0] n;
    int c;
    acc = sym_valid && m_ready();
    if (m_pos == 9) begin
      m_idle = 0;
      if (m_q.size() != 0) begin
        n = m_q.pop_front();
        if (acc) m_q.push_back(sym_in);
      end else if (acc) n = sym_in;
      else begin
        n = m_rd ? KP : KN;
        m_idle = 1;
      end
      c = $countones(n);
      if (c == 6) m_rd = 1;
      else if (c == 4) m_rd = 0;
      else if (c != 5) m_err = 1;
      m_cur = n;
      m_pos = 0;
    end else begin
      m_pos++;
      if (acc) m_q.push_back(sym_in);
    end
  endfunction
  task automatic chk(string n, logic [9:0] act, logic [9:0] exp);
    tot++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b at %0t", n, act, exp, $time);
  endtask
  task automatic tick();
    chk("m_ser", ser_out, m_cur[9-m_pos]);
    chk("m_ready", sym_ready, m_ready());
    chk("m_start", sym_start, m_pos == 0);
    chk("m_idle", is_idle, m_idle);
    chk("m_rd", rd_out, m_rd);
    chk("m_err", disp_err, m_err);
    got.push_back(ser_out);
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask
  task automatic chk_reset_vals();
    chk("rst_ser", ser_out, 0);
    chk("rst_ready", sym_ready, 1);
    chk("rst_start", sym_start, 0);
    chk("rst_idle", is_idle, 0);
    chk("rst_rd", rd_out, 0);
    chk("rst_err", disp_err, 0);
  endtask
  task automatic do_reset();
    rst_n = 0; sym_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals();
    rst_n = 1;
    m_reset();
    got.delete();
  endtask
  task automatic chk_bits(string n, int from, logic [9:0] exp);
    logic [9:0] a;
    for (int i = 0; i < 10; i++) a[9-i] = got[from+i];
    chk(n, a, exp);
  endtask
  function automatic logic [9:0] rnd_sym();
    logic [9:0] s;
    if ($urandom_range(19) == 0) return 10'($urandom);
    do s = 10'($urandom); while ($countones(s) < 4 || $countones(s) > 6);
    return s;
  endfunction
  typedef struct {
    logic v;
    logic [9:0] s;
    logic ser, rdy, st, idl, rdo;
  } vec_t;
  vec_t tbl[14];
  int rdy_hi;
  initial begin
    tbl[0]  = '{1, D00, 0, 1, 0, 0, 0};
    tbl[1]  = '{0, '0, 1, 1, 1, 0, 0};
    tbl[2]  = '{0, '0, 0, 1, 0, 0, 0};
    tbl[3]  = '{0, '0, 0, 1, 0, 0, 0};
    tbl[4]  = '{0, '0, 1, 1, 0, 0, 0};
    tbl[5]  = '{0, '0, 1, 1, 0, 0, 0};
    tbl[6]  = '{0, '0, 1, 1, 0, 0, 0};
    tbl[7]  = '{0, '0, 0, 1, 0, 0, 0};
    tbl[8]  = '{0, '0, 1, 1, 0, 0, 0};
    tbl[9]  = '{0, '0, 0, 1, 0, 0, 0};
    tbl[10] = '{0, '0, 0, 1, 0, 0, 0};
    tbl[11] = '{0, '0, 0, 1, 1, 1, 1};
    tbl[12] = '{0, '0, 0, 1, 0, 1, 1};
    tbl[13] = '{0, '0, 1, 1, 0, 1, 1};
    // idle stream after reset
    do_reset();
    for (int c = 0; c < 31; c++) tick();
    chk_bits("idle_neg", 1, KN);
    chk_bits("idle_pos", 11, KP);
    chk_bits("idle_neg2", 21, KN);
    // single data symbol on the first load cycle
    do_reset();
    for (int i = 0; i < 14; i++) begin
      sym_valid = tbl[i].v;
      sym_in = tbl[i].s;
      chk($sformatf("tbl%0d_ser", i), ser_out, tbl[i].ser);
      chk($sformatf("tbl%0d_ready", i), sym_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_start", i), sym_start, tbl[i].st);
      chk($sformatf("tbl%0d_idle", i), is_idle, tbl[i].idl);
      chk($sformatf("tbl%0d_rd", i), rd_out, tbl[i].rdo);
      tick();
    end
    // back-to-back symbols with a continuously valid source
    do_reset();
    rdy_hi = 0;
    for (int c = 0; c <= 30; c++) begin
      sym_valid = 1;
      sym_in = c == 1 ? SB : SA;
      if (c >= 11 && sym_ready) rdy_hi++;
      if (c == 11) chk("b2b_rd_after_b", rd_out, 1);
      if (c == 11) chk("b2b_idle", is_idle, 0);
      tick();
    end
    sym_valid = 0;
    chk_bits("b2b_a", 1, SA);
    chk_bits("b2b_b", 11, SB);
    chk_bits("b2b_a2", 21, SA);
    chk("b2b_ready_count", 10'(rdy_hi), 10'd2);
    // bad ones-count symbol
    do_reset();
    sym_valid = 1; sym_in = 10'h3FF;
    tick();
    sym_valid = 0;
    for (int c = 1; c < 30; c++) tick();
    chk_bits("err_bits", 1, 10'h3FF);
    chk("err_sticky", disp_err, 1);
    // reset in the middle of a symbol while hold is full
    do_reset();
    sym_valid = 1; sym_in = SA;
    tick();
    sym_in = SB;
    tick();
    sym_valid = 0;
    for (int c = 2; c < 5; c++) tick();
    rst_n = 0;
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1;
    m_reset();
    got.delete();
    for (int c = 0; c < 21; c++) tick();
    chk_bits("rst_mid_neg", 1, KN);
    chk_bits("rst_mid_pos", 11, KP);
    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      logic acc;
      acc = sym_valid && m_ready();
      tick();
      if (acc || !sym_valid) begin
        sym_valid = $urandom_range(3) != 0;
        sym_in = rnd_sym();
      end
    end
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule
